// File: rtl/ddr_line_arbiter.sv
// rtl/ddr_line_arbiter.sv - two-master round-robin line arbiter onto a single DDR slave port
module ddr_line_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  m0_addr,
  input  logic [511:0] m0_dout,
  input  logic [63:0]  m0_dm,
  input  logic         m0_we,
  input  logic         m0_cyc,
  input  logic         m0_stb,
  output logic         m0_ack,
  output logic [511:0] m0_din,
  input  logic [31:0]  m1_addr,
  input  logic [511:0] m1_dout,
  input  logic [63:0]  m1_dm,
  input  logic         m1_we,
  input  logic         m1_cyc,
  input  logic         m1_stb,
  output logic         m1_ack,
  output logic [511:0] m1_din,
  output logic [31:0]  s_addr,
  output logic [511:0] s_dout,
  output logic [63:0]  s_dm,
  output logic         s_we,
  output logic         s_cyc,
  output logic         s_stb,
  input  logic         s_ack,
  input  logic [511:0] s_din,
  output logic [1:0]   grant,
  output logic         timeout_err,
  input  logic         err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN, ISSUE, RESP} state_t;

  state_t          state;
  logic            last_grant;   // 0 = m0 was granted last, 1 = m1
  logic [CW-1:0]   tcnt;
  logic [CW-1:0]   tcnt_inc;
  logic            abandon;      // owner dropped cyc at some point during ISSUE
  logic            own;          // 0 = m0 owns the bus, 1 = m1
  logic            own_cyc;
  logic            own_stb;
  logic [31:0]     own_addr;
  logic [511:0]    own_dout;
  logic [63:0]     own_dm;
  logic            own_we;
  logic            pick;

  // Owner request mux and round-robin pick for the next arbitration
  always_comb begin
    own      = grant[1];
    own_cyc  = own ? m1_cyc  : m0_cyc;
    own_stb  = own ? m1_stb  : m0_stb;
    own_addr = own ? m1_addr : m0_addr;
    own_dout = own ? m1_dout : m0_dout;
    own_dm   = own ? m1_dm   : m0_dm;
    own_we   = own ? m1_we   : m0_we;
    pick     = (m0_cyc && m1_cyc) ? ~last_grant : m1_cyc;
    tcnt_inc = tcnt + CW'(1);
  end

  // Arbitration FSM with all slave-side and master-side outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 2'b00;
      s_cyc       <= 1'b0;
      s_stb       <= 1'b0;
      s_we        <= 1'b0;
      s_addr      <= '0;
      s_dout      <= '0;
      s_dm        <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_din      <= '0;
      m1_din      <= '0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      abandon     <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      // a timeout set later in this block overrides the clear
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_cyc || m1_cyc) begin
            grant      <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            s_cyc      <= 1'b1;
            state      <= OWN;
          end
        end
        OWN: begin
          if (own_stb) begin
            s_addr  <= own_addr;
            s_dout  <= own_dout;
            s_dm    <= own_dm;
            s_we    <= own_we;
            s_stb   <= 1'b1;
            tcnt    <= '0;
            abandon <= 1'b0;
            state   <= ISSUE;
          end else if (!own_cyc) begin
            grant <= 2'b00;
            s_cyc <= 1'b0;
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (s_ack) begin
            s_stb <= 1'b0;
            if (abandon || !own_cyc) begin
              grant <= 2'b00;
              s_cyc <= 1'b0;
              state <= IDLE;
            end else begin
              if (own) begin
                m1_ack <= 1'b1;
                m1_din <= s_din;
              end else begin
                m0_ack <= 1'b1;
                m0_din <= s_din;
              end
              state <= RESP;
            end
          end else begin
            tcnt <= tcnt_inc;
            if (!own_cyc) abandon <= 1'b1;
            if (tcnt_inc == TMAX) begin
              s_stb       <= 1'b0;
              s_cyc       <= 1'b0;
              grant       <= 2'b00;
              timeout_err <= 1'b1;
              if (!(abandon || !own_cyc)) begin
                if (own) begin
                  m1_ack <= 1'b1;
                  m1_din <= '0;
                end else begin
                  m0_ack <= 1'b1;
                  m0_din <= '0;
                end
              end
              state <= IDLE;
            end
          end
        end
        RESP: begin
          state <= OWN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_line_arbiter.sv
// tb/tb_ddr_line_arbiter.sv - directed self-checking bench for ddr_line_arbiter
module tb_ddr_line_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  m0_addr, m1_addr;
  logic [511:0] m0_dout, m1_dout;
  logic [63:0]  m0_dm, m1_dm;
  logic         m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic         m0_ack, m1_ack;
  logic [511:0] m0_din, m1_din;
  logic [31:0]  s_addr;
  logic [511:0] s_dout;
  logic [63:0]  s_dm;
  logic         s_we, s_cyc, s_stb, s_ack;
  logic [511:0] s_din;
  logic [1:0]   grant;
  logic         timeout_err, err_clr;

  int total = 0;
  int bad = 0;

  ddr_line_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_dm(m0_dm), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_din(m0_din),
    .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_dm(m1_dm), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_din(m1_din),
    .s_addr(s_addr), .s_dout(s_dout), .s_dm(s_dm), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_ack(s_ack), .s_din(s_din),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic cyc, input logic stb, input logic [31:0] addr,
                         input logic we, input logic [511:0] d, input logic [63:0] dm);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_addr = addr; m0_we = we; m0_dout = d; m0_dm = dm;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_addr = addr; m1_we = we; m1_dout = d; m1_dm = dm;
    end
  endtask

  // One transfer by a master that already owns the bus (FSM in OWN); lat = ISSUE cycles before ack
  task automatic xfer(input int m, input logic [31:0] addr, input logic we, input logic [511:0] wd,
                      input logic [63:0] dm, input logic [511:0] rd, input int lat);
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    set_req(m, 1'b1, 1'b1, addr, we, wd, dm);
    tick;
    check("issue_stb", s_stb, 1'b1);
    check("issue_addr", s_addr, addr);
    check("issue_we", s_we, we);
    check("issue_dout", s_dout, wd);
    check("issue_dm", s_dm, dm);
    check("issue_grant", grant, g);
    for (int i = 1; i < lat; i++) begin
      tick;
      check("hold_stb", s_stb, 1'b1);
      check("hold_addr", s_addr, addr);
      check("hold_cyc", s_cyc, 1'b1);
    end
    s_ack = 1'b1;
    s_din = rd;
    tick;
    s_ack = 1'b0;
    s_din = '0;
    check("resp_ack", (m == 0) ? m0_ack : m1_ack, 1'b1);
    check("resp_other_ack", (m == 0) ? m1_ack : m0_ack, 1'b0);
    check("resp_din", (m == 0) ? m0_din : m1_din, rd);
    check("resp_stb", s_stb, 1'b0);
    check("resp_cyc", s_cyc, 1'b1);
    set_req(m, 1'b1, 1'b0, addr, we, wd, dm);
    tick;
    check("ack_pulse_end", (m == 0) ? m0_ack : m1_ack, 1'b0);
    check("own_cyc", s_cyc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] pa, pb, pc, pd, pe;
    int cnt;
    pa = {16{32'hA5A5_0001}};
    pb = {16{32'h0B0B_0002}};
    pc = {16{32'hC3C3_0003}};
    pd = {16{32'hDDDD_0004}};
    pe = {16{32'hE1E1_0005}};
    rst_n = 1'b0; s_ack = 1'b0; s_din = '0; err_clr = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_sstb", s_stb, 1'b0);
    check("rst_saddr", s_addr, 32'h0);
    check("rst_m0din", m0_din, '0);
    check("rst_err", timeout_err, 1'b0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("idle_grant", grant, 2'b00);

    // tie right after reset: m0 first, then m1, then m0 again
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick;
    check("tie1_grant", grant, 2'b01);
    check("tie1_scyc", s_cyc, 1'b1);
    m0_cyc = 1'b0;
    tick;
    check("dead_grant", grant, 2'b00);
    check("dead_scyc", s_cyc, 1'b0);
    tick;
    check("tie1_m1_grant", grant, 2'b10);
    m1_cyc = 1'b0;
    tick;
    check("rel_m1_grant", grant, 2'b00);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick;
    check("tie2_grant", grant, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick;

    // single read by m0, slave acks 3 cycles after s_stb
    m0_cyc = 1'b1;
    tick;
    check("rd_grant", grant, 2'b01);
    check("rd_stb_pre", s_stb, 1'b0);
    xfer(0, 32'h0000_1040, 1'b0, '0, '0, pa, 3);
    check("rd_m1_ack", m1_ack, 1'b0);
    m0_cyc = 1'b0;
    tick;
    check("rd_release", grant, 2'b00);

    // locked tenure: m0 read then write while m1 keeps requesting
    m0_cyc = 1'b1;
    tick;
    check("lock_grant", grant, 2'b01);
    m1_cyc = 1'b1;
    xfer(0, 32'h0000_2080, 1'b0, '0, '0, pb, 2);
    xfer(0, 32'hDEAD_BEEF, 1'b1, pc, 64'hFFFF_FFFF_FFFF_FFFF, pd, 1);
    check("lock_still_m0", grant, 2'b01);
    m0_cyc = 1'b0;
    tick;
    check("lock_release", grant, 2'b00);
    tick;
    check("lock_m1_grant", grant, 2'b10);

    // m1 read to give m1_din a known value, then abandon the next one
    xfer(1, 32'h0000_3001, 1'b0, '0, '0, pc, 2);
    m1_stb = 1'b1; m1_addr = 32'h0000_4000;
    tick;
    check("ab_stb", s_stb, 1'b1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick; tick;
    check("ab_hold_stb", s_stb, 1'b1);
    check("ab_hold_cyc", s_cyc, 1'b1);
    s_ack = 1'b1; s_din = pe;
    tick;
    s_ack = 1'b0; s_din = '0;
    check("ab_no_ack", m1_ack, 1'b0);
    check("ab_din_kept", m1_din, pc);
    check("ab_idle_grant", grant, 2'b00);
    check("ab_cyc", s_cyc, 1'b0);
    tick;
    check("ab_no_ack2", m1_ack, 1'b0);

    // timeout with a slave that never acks
    m0_cyc = 1'b1;
    tick;
    check("to_grant", grant, 2'b01);
    m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_5000;
    tick;
    cnt = 0;
    for (int i = 0; i < 40 && s_stb; i++) begin
      cnt++;
      tick;
    end
    check("to_cycles", cnt, 15);
    check("to_ack", m0_ack, 1'b1);
    check("to_din", m0_din, '0);
    check("to_err", timeout_err, 1'b1);
    check("to_cyc", s_cyc, 1'b0);
    check("to_grant_rel", grant, 2'b00);
    m0_stb = 1'b0; m0_cyc = 1'b0;
    tick;
    check("to_ack_end", m0_ack, 1'b0);
    tick;
    check("to_err_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("to_err_clr", timeout_err, 1'b0);

    // ack in the same cycle the counter would expire: ack wins
    m0_cyc = 1'b1;
    tick;
    m0_stb = 1'b1;
    tick;
    repeat (14) tick;
    check("co_stb", s_stb, 1'b1);
    s_ack = 1'b1; s_din = pe;
    tick;
    s_ack = 1'b0; s_din = '0;
    check("co_ack", m0_ack, 1'b1);
    check("co_din", m0_din, pe);
    check("co_err", timeout_err, 1'b0);
    check("co_cyc", s_cyc, 1'b1);
    m0_stb = 1'b0;
    tick;

    // timeout while err_clr is held: set wins, then clear takes effect
    m0_stb = 1'b1; err_clr = 1'b1;
    tick;
    cnt = 0;
    for (int i = 0; i < 40 && s_stb; i++) begin
      cnt++;
      tick;
    end
    check("to2_cycles", cnt, 15);
    check("to2_set_wins", timeout_err, 1'b1);
    tick;
    check("to2_cleared", timeout_err, 1'b0);
    err_clr = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    tick;

    // asynchronous reset in the middle of ISSUE
    m0_cyc = 1'b1;
    tick;
    m0_stb = 1'b1;
    tick;
    check("ar_stb_pre", s_stb, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_stb", s_stb, 1'b0);
    check("ar_cyc", s_cyc, 1'b0);
    check("ar_grant", grant, 2'b00);
    check("ar_din", m0_din, '0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick;
    check("ar_ack", m0_ack, 1'b0);
    rst_n = 1'b1;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick;
    check("ar_restart_grant", grant, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
